// File: rtl/ddr_lane_dly_ctrl.sv
// ddr_lane_dly_ctrl -- walks every IOD delay line of one DDR lane to its target tap,
// one line at a time. Each line can first be loaded to INIT_TAP. It is then stepped
// one tap per MOVE pulse, with a settle gap after every LOAD/MOVE pulse.
// The controller keeps its own copy of each line's tap count and reports it on CUR_TAP.
// Build option: define DDR_LANE_DLY_OOR_ABORT_EN to abort the whole sequence on the first
// out-of-range event. Without it, only the offending line is abandoned.
module ddr_lane_dly_ctrl #(
  parameter int NUM_BITS = 9,
  parameter int TAP_W    = 8,
  parameter int INIT_TAP = 1,
  parameter int MOVE_GAP = 4
) (
  input  logic                      FAB_CLK,
  input  logic                      ARST,
  input  logic                      START,
  input  logic                      LOAD_FIRST,
  input  logic [NUM_BITS*TAP_W-1:0] TARGET_TAP,
  input  logic [NUM_BITS-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_BITS-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_BITS-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_BITS-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_BITS*TAP_W-1:0] CUR_TAP,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [NUM_BITS-1:0]       ERR
);

  localparam int CH_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_BITS - 1);
  localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
  localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MOVE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] TAP_MAX  = {TAP_W{1'b1}};
  localparam logic [TAP_W-1:0] TAP_MIN  = {TAP_W{1'b0}};
  localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SEL    = 3'd2,
    S_STEP   = 3'd3,
    S_GAP    = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  // Where an out-of-range line sends the sequence: end it, or skip to the next line.
`ifdef DDR_LANE_DLY_OOR_ABORT_EN
  localparam state_t OOR_DEST = S_FINISH;
`else
  localparam state_t OOR_DEST = S_NEXT;
`endif

  state_t                            state_q, state_d;
  logic [CH_W-1:0]                   ch_q, ch_d;
  logic [GAP_W-1:0]                  gap_q, gap_d;
  logic                              lf_q, lf_d;
  logic [NUM_BITS-1:0][TAP_W-1:0]    tgt_q, tgt_d;
  logic [NUM_BITS-1:0][TAP_W-1:0]    cur_q, cur_d;
  logic [NUM_BITS-1:0]               dir_q, dir_d;
  logic [NUM_BITS-1:0]               load_q, load_d;
  logic [NUM_BITS-1:0]               move_q, move_d;
  logic [NUM_BITS-1:0]               err_q, err_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;

  // Per-line view of the line currently being trimmed.
  logic [TAP_W-1:0] cur_ch_s;
  logic [TAP_W-1:0] tgt_ch_s;
  logic             hit_s;
  logic             up_s;
  logic             at_limit_s;
  logic             oor_ch_s;

  assign cur_ch_s   = cur_q[ch_q];
  assign tgt_ch_s   = tgt_q[ch_q];
  assign hit_s      = (tgt_ch_s == cur_ch_s);
  assign up_s       = (tgt_ch_s > cur_ch_s);
  // A step that would wrap the tracked count is refused and treated as out of range.
  assign at_limit_s = up_s ? (cur_ch_s == TAP_MAX) : (cur_ch_s == TAP_MIN);
  assign oor_ch_s   = DELAY_LINE_OUT_OF_RANGE[ch_q];

  // Next-state, line bookkeeping, and the pulse outputs for the state being entered.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    gap_d   = gap_q;
    lf_d    = lf_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    dir_d   = dir_q;
    err_d   = err_q;
    busy_d  = busy_q;
    load_d  = {NUM_BITS{1'b0}};
    move_d  = {NUM_BITS{1'b0}};
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          tgt_d   = TARGET_TAP;
          lf_d    = LOAD_FIRST;
          err_d   = {NUM_BITS{1'b0}};
          ch_d    = CH_ZERO;
          busy_d  = 1'b1;
          state_d = LOAD_FIRST ? S_LOAD : S_SEL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cur_d[ch_q] = TAP_INIT;
        gap_d       = GAP_LOAD;
        state_d     = S_GAP;
      end
      S_SEL: begin
        if (hit_s) begin
          state_d = S_NEXT;
        end else if (at_limit_s) begin
          err_d[ch_q] = 1'b1;
          state_d     = OOR_DEST;
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        cur_d[ch_q] = dir_q[ch_q] ? (cur_ch_s + TAP_ONE) : (cur_ch_s - TAP_ONE);
        gap_d       = GAP_LOAD;
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_ZERO) begin
          if (oor_ch_s) begin
            err_d[ch_q] = 1'b1;
            state_d     = OOR_DEST;
          end else begin
            state_d = S_SEL;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      S_NEXT: begin
        if (ch_q == LAST_CH) begin
          state_d = S_FINISH;
        end else begin
          ch_d    = ch_q + CH_ONE;
          state_d = lf_q ? S_LOAD : S_SEL;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Pulses are registered so they are high exactly during the LOAD/STEP/FINISH cycle.
    load_d[ch_d] = (state_d == S_LOAD);
    move_d[ch_d] = (state_d == S_STEP);
    done_d       = (state_d == S_FINISH);

    // Direction is settled on SEL entry, one full cycle ahead of the MOVE pulse.
    if ((state_d == S_SEL) && (tgt_d[ch_d] != cur_d[ch_d])) begin
      dir_d[ch_d] = (tgt_d[ch_d] > cur_d[ch_d]);
    end else begin
      dir_d[ch_d] = dir_q[ch_d];
    end
  end

  // State and output registers; reset puts every line back at INIT_TAP.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= S_IDLE;
      ch_q    <= CH_ZERO;
      gap_q   <= GAP_ZERO;
      lf_q    <= 1'b0;
      tgt_q   <= {NUM_BITS{TAP_INIT}};
      cur_q   <= {NUM_BITS{TAP_INIT}};
      dir_q   <= {NUM_BITS{1'b0}};
      load_q  <= {NUM_BITS{1'b0}};
      move_q  <= {NUM_BITS{1'b0}};
      err_q   <= {NUM_BITS{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      gap_q   <= gap_d;
      lf_q    <= lf_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      move_q  <= move_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign CUR_TAP              = cur_q;
  assign BUSY                 = busy_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;

endmodule
